// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter/sequencer.
package alu_arbiter_pkg;

   // Sequencer states: accept a request, run it through the ALU, return the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Opcodes understood by the external 8-bit ALU.
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_NOT = 2'b11;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic with a last-grant pointer.
// A lone requester always wins; on a tie the requester not granted last wins.
module rr_arbiter2
   import alu_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       update_en_i,
   output logic [1:0] grant_o
);

   logic last_q;
   logic last_d;

   // One-hot grant from the requests and the last-grant pointer.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      grant_o = req_i;
      if (req_i == 2'b11) begin
         grant_o = last_q ? 2'b01 : 2'b10;
      end
   end

   // Pointer follows every grant taken while updates are enabled.
   always_comb begin
      last_d = last_q;
      if (update_en_i && (grant_o != 2'b00)) begin
         last_d = grant_o[1];
      end
   end

   // Pointer register; reset to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer in front of a shared combinational ALU.
// One operation in flight: IDLE accepts, EXEC captures the ALU result, RESP returns it.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_data,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_data,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result
);

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             rsp0_valid_q, rsp0_valid_d;
   logic             rsp1_valid_q, rsp1_valid_d;
   logic [WIDTH-1:0] rsp0_data_q, rsp0_data_d;
   logic [WIDTH-1:0] rsp1_data_q, rsp1_data_d;
   logic [1:0]       grant;
   logic             idle;

   assign idle = (state_q == IDLE);

   rr_arbiter2 u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_i       ({req1_valid, req0_valid}),
      .update_en_i (idle),
      .grant_o     (grant)
   );

   // Ready is combinational: only the winner, only while idle.
   assign req0_ready = idle & grant[0];
   assign req1_ready = idle & grant[1];

   // The ALU is driven from the operand registers at all times.
   assign alu_op     = op_q;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp0_data  = rsp0_data_q;
   assign rsp1_data  = rsp1_data_q;

   // Next-state and register-update logic for the accept/execute/respond sequence.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      rsp0_valid_d = rsp0_valid_q;
      rsp1_valid_d = rsp1_valid_q;
      rsp0_data_d  = rsp0_data_q;
      rsp1_data_d  = rsp1_data_q;
      unique case (state_q)
         IDLE: begin
            if (grant != 2'b00) begin
               owner_d = grant[1];
               op_d    = grant[1] ? req1_op : req0_op;
               a_d     = grant[1] ? req1_a  : req0_a;
               b_d     = grant[1] ? req1_b  : req0_b;
               state_d = EXEC;
            end
         end
         EXEC: begin
            rsp0_valid_d = ~owner_q;
            rsp1_valid_d = owner_q;
            rsp0_data_d  = owner_q ? '0 : alu_result;
            rsp1_data_d  = owner_q ? alu_result : '0;
            state_d      = RESP;
         end
         RESP: begin
            if ((!owner_q && rsp0_ready) || (owner_q && rsp1_ready)) begin
               rsp0_valid_d = 1'b0;
               rsp1_valid_d = 1'b0;
               rsp0_data_d  = '0;
               rsp1_data_d  = '0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, operand and response registers.
   always_ff @(posedge clk) begin
      // NOTE: operand and result registers are reset too, because they drive outputs with defined reset values.
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         op_q         <= ALU_ADD;
         a_q          <= '0;
         b_q          <= '0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_data_q  <= '0;
         rsp1_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp0_data_q  <= rsp0_data_d;
         rsp1_data_q  <= rsp1_data_d;
      end
   end

endmodule
